usr_shift_controller: RTL and testbench
=======================================

# usr_shift_controller

Command sequencer for the N-bit universal shift register (fn: 00 hold, 01 shift left, 10 shift right, 11 parallel load). The block accepts one command at a time over a valid/ready handshake and expands it into per-cycle fn, serial-in and parallel-in drive for the register. It reads the register outputs back to supply rotate and arithmetic fill bits, and pulses done when the sequence has finished. It sits between a bus-side command source and the shift register datapath.

## Interface
- N, 4: register width, ≥2
- CW, $clog2(N+1): shift-count width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept (IDLE only)
- cmd_op  in  3  000 NOP, 001 CLEAR, 010 LOAD, 011 SHL, 100 SHR, 101 ROL, 110 ROR, 111 ASR
- cmd_cnt  in  CW  shift amount
- cmd_data  in  N  load value
- cmd_fill  in  1  serial fill bit for SHL/SHR
- abort  in  1  terminate a shift sequence
- sr_q  in  N  register outputs (feedback)
- sr_fn  out  2  register function select
- sr_sli, sr_sri  out  1  serial inputs to bit 0 / bit N-1
- sr_in  out  N  parallel load data
- sr_clear  out  1  register clear, active high
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, rejected op
- remaining  out  CW  shifts still pending

## Operation
- States: IDLE, CLR, LOAD, SHIFT, DONE.
- Accept occurs when cmd_valid and cmd_ready are both high at a rising edge. The controller latches op, cnt, data and fill.
- IDLE: sr_fn=00, cmd_ready=1.
- NOP goes to DONE.
- CLEAR goes to CLR. CLR drives sr_clear=1 for one cycle, then goes to DONE.
- LOAD goes to LOAD. LOAD drives sr_fn=11 and sr_in=latched data for one cycle, then goes to DONE.
- SHL/SHR/ROL/ROR/ASR:
  - Effective count = min(cnt, N).
  - A count of 0 goes directly to DONE with no shift.
  - Otherwise the controller goes to SHIFT with remaining=effective count.
- SHIFT drives sr_fn=01 for SHL/ROL and 10 for SHR/ROR/ASR.
  - SHL: sli = fill. ROL: sli = sr_q[N-1].
  - SHR: sri = fill. ROR: sri = sr_q[0]. ASR: sri = sr_q[N-1].
  - Serial outputs not in use are driven 0.
  - remaining decrements every cycle. When the cycle with remaining=1 completes, the controller goes to DONE.
- DONE: sr_fn=00, done=1 for one cycle, then IDLE.
- abort is sampled in SHIFT only.
  - When abort is high, that cycle drives sr_fn=00 (no shift), remaining is cleared to 0, and the controller goes to DONE.
  - abort is ignored in all other states.
- cmd_valid while busy is ignored and not queued. The source must hold it until accepted.
- sr_in is driven with the latched data in all states, so it is stable outside LOAD.

## Timing
- Reset values: sr_fn=00, sr_sli=0, sr_sri=0, sr_in=0, sr_clear=0, cmd_ready=1, busy=0, done=0, err=0, remaining=0. State is IDLE.
- Reset asserted mid-sequence forces all of the above immediately, with no completing done.
- All outputs are registered-state decodes; there are no combinational paths from cmd_* to sr_*.
- Accept at edge T:
  - LOAD/CLEAR are active in cycle T+1; done is high in cycle T+2; cmd_ready returns at T+3.
  - A shift of k (1..N) is active in cycles T+1..T+k; done is high at T+k+1.
  - NOP or a count of 0 gives done at T+1.
- Back-to-back throughput: one command every (active cycles + 2).
- Rotate feedback uses sr_q as sampled in the same cycle. A rotate of N returns the original value.

## Configuration
- USR_CTRL_ROTATE_EN defined: ROL, ROR and ASR are supported as above.
- Not defined:
  - Ops 101/110/111 are accepted, err pulses for one cycle at T+1, and the controller then goes to DONE (done at T+2) with no register activity.
  - The feedback logic is compiled out, and sr_q is unused.

## Structure
- Shared package usr_ctrl_pkg:
  - op enum (NOP..ASR)
  - state enum
  - fn constants FN_HOLD=2'b00, FN_SHL=2'b01, FN_SHR=2'b10, FN_LOAD=2'b11
- Sub-module shift_counter: a CW-bit down-counter with load, decrement, clear and zero flag. It drives remaining.
- The FSM, latch registers and serial-bit mux stay in the top module.

## Test plan
- Reset with rst_n=0 mid-SHIFT → within the same cycle sr_fn=00, busy=0, remaining=0; no done.
- N=4: LOAD 4'b1011 → sr_fn=11 for one cycle, done the cycle after; register holds 1011.
- After LOAD 1011, SHL cnt=2 fill=0 → sr_fn=01 for 2 cycles, remaining 2→1→0; register 1100; done at T+3.
- After LOAD 1001, ROR cnt=1 → sri=1, register 1100. Then ASR cnt=6 → clamped to 4 shifts, register 1111.
- SHR cnt=3 with abort at second shift cycle → exactly one shift; done the following cycle; cmd_valid asserted while busy is not accepted.
- Without USR_CTRL_ROTATE_EN: ROL cnt=2 → err pulse at T+1, done at T+2, sr_fn stays 00 throughout.

Source files
------------

// File: rtl/usr_ctrl_pkg.sv
// Shared types for the universal shift register command sequencer:
// command opcodes, FSM states and register function-select encodings.
package usr_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_CLEAR = 3'b001,
    OP_LOAD  = 3'b010,
    OP_SHL   = 3'b011,
    OP_SHR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_ROR   = 3'b110,
    OP_ASR   = 3'b111
  } op_t;

  // S_ERR is only reachable when rotate/arithmetic ops are compiled out.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] FN_HOLD = 2'b00;
  localparam logic [1:0] FN_SHL  = 2'b01;
  localparam logic [1:0] FN_SHR  = 2'b10;
  localparam logic [1:0] FN_LOAD = 2'b11;

endpackage

// File: rtl/usr_shift_controller_if.sv
// Command-side bus of the shift controller: one command per valid/ready handshake.
interface usr_shift_controller_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  // A command transfers on a rising edge where cmd_valid and cmd_ready are both
  // high; the source holds cmd_valid and the payload stable until that edge, and
  // cmd_ready never depends combinationally on cmd_valid.
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [N-1:0]  cmd_data;
  logic          cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/shift_counter.sv
// Down-counter tracking the shifts still pending; clear beats load beats decrement.
module shift_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/usr_shift_controller.sv
// Command sequencer for an N-bit universal shift register.
// Define USR_CTRL_ROTATE_EN to support ROL/ROR/ASR; otherwise those ops pulse err.
module usr_shift_controller
  import usr_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  usr_shift_controller_if.slave  cmd,
  input  logic                   abort,
  input  logic [N-1:0]           sr_q,
  output logic [1:0]             sr_fn,
  output logic                   sr_sli,
  output logic                   sr_sri,
  output logic [N-1:0]           sr_in,
  output logic                   sr_clear,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CW-1:0]          remaining,
  output state_t                 o_dbg_state
);

  state_t        r_state, w_next;
  op_t           r_op;
  logic [N-1:0]  r_data;
  logic          r_fill;

  op_t           w_cmd_op;
  logic          w_accept;
  logic [CW-1:0] w_eff_cnt;
  logic          w_cnt_load, w_cnt_dec, w_cnt_clr, w_cnt_zero;
  logic          w_shifting;

  assign w_cmd_op  = op_t'(cmd.cmd_op);
  assign w_accept  = cmd.cmd_valid && cmd.cmd_ready;
  assign w_eff_cnt = (cmd.cmd_cnt > CW'(N)) ? CW'(N) : cmd.cmd_cnt;

  shift_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_eff_cnt),
    .i_dec      (w_cnt_dec),
    .i_clr      (w_cnt_clr),
    .o_count    (remaining),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_data  <= '0;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= w_cmd_op;
        r_data <= cmd.cmd_data;
        r_fill <= cmd.cmd_fill;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_cmd_op)
            OP_NOP:   w_next = S_DONE;
            OP_CLEAR: w_next = S_CLR;
            OP_LOAD:  w_next = S_LOAD;
            OP_SHL, OP_SHR: begin
              w_cnt_load = 1'b1;
              w_next     = (w_eff_cnt == '0) ? S_DONE : S_SHIFT;
            end
`ifdef USR_CTRL_ROTATE_EN
            default: begin
              w_cnt_load = 1'b1;
              w_next     = (w_eff_cnt == '0) ? S_DONE : S_SHIFT;
            end
`else
            default: w_next = S_ERR;
`endif
          endcase
        end
      end
      S_CLR, S_LOAD, S_ERR: w_next = S_DONE;
      S_SHIFT: begin
        // An aborted cycle performs no shift and discards the pending count.
        if (abort) begin
          w_cnt_clr = 1'b1;
          w_next    = S_DONE;
        end else begin
          w_cnt_dec = 1'b1;
          if ((remaining == CW'(1)) || w_cnt_zero) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign err           = (r_state == S_ERR);
  assign sr_clear      = (r_state == S_CLR);
  assign sr_in         = r_data;
  assign o_dbg_state   = r_state;
  assign w_shifting    = (r_state == S_SHIFT) && !abort;

  // Serial fill mux: rotate/arithmetic feedback reads sr_q in the shifting cycle.
  always_comb begin
    sr_fn  = FN_HOLD;
    sr_sli = 1'b0;
    sr_sri = 1'b0;
    if (r_state == S_LOAD) begin
      sr_fn = FN_LOAD;
    end else if (w_shifting) begin
      case (r_op)
        OP_SHL: begin sr_fn = FN_SHL; sr_sli = r_fill;   end
        OP_SHR: begin sr_fn = FN_SHR; sr_sri = r_fill;   end
`ifdef USR_CTRL_ROTATE_EN
        OP_ROL: begin sr_fn = FN_SHL; sr_sli = sr_q[N-1]; end
        OP_ROR: begin sr_fn = FN_SHR; sr_sri = sr_q[0];   end
        OP_ASR: begin sr_fn = FN_SHR; sr_sri = sr_q[N-1]; end
`endif
        default: ;
      endcase
    end
  end

`ifndef USR_CTRL_ROTATE_EN
  logic w_unused_sr_q;
  assign w_unused_sr_q = ^sr_q;
`endif

endmodule

// File: tb/tb_usr_shift_controller.sv
// Directed bench for usr_shift_controller driving a behavioural universal shift register.
`timescale 1ns/1ps
module tb_usr_shift_controller;
  import usr_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  sr_q;
  logic [1:0]    sr_fn;
  logic          sr_sli, sr_sri, sr_clear, busy, done, err;
  logic [N-1:0]  sr_in;
  logic [CW-1:0] remaining;
  state_t        dbg_state;

  usr_shift_controller_if #(.N(N), .CW(CW)) cmd_if ();

  usr_shift_controller #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .abort       (abort),
    .sr_q        (sr_q),
    .sr_fn       (sr_fn),
    .sr_sli      (sr_sli),
    .sr_sri      (sr_sri),
    .sr_in       (sr_in),
    .sr_clear    (sr_clear),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .remaining   (remaining),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Behavioural universal shift register: 01 left (sli into bit 0), 10 right (sri into bit N-1).
  logic [N-1:0] reg_q = '0;
  always @(posedge clk) begin
    if (sr_clear) reg_q <= '0;
    else begin
      case (sr_fn)
        2'b01:   reg_q <= {reg_q[N-2:0], sr_sli};
        2'b10:   reg_q <= {sr_sri, reg_q[N-1:1]};
        2'b11:   reg_q <= sr_in;
        default: reg_q <= reg_q;
      endcase
    end
  end
  assign sr_q = reg_q;

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [CW-1:0] cnt;
    logic [N-1:0]  data;
    logic          fill;
    logic [N-1:0]  exp_reg;
    int            exp_lat;
    int            exp_act;
    int            exp_err;
    logic [CW-1:0] exp_rem1;
  } vec_t;

  vec_t vecs[$];

  // driver tasks
  task automatic wait_ready(input string name);
    @(negedge clk);
    for (int w = 0; w < 10 && !cmd_if.cmd_ready; w++) @(negedge clk);
    check({name, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt,
                       input logic [N-1:0] data, input logic fill);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_cnt   = cnt;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_fill  = fill;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, act, errs;
    logic [CW-1:0] rem1;
    string tag;
    lat  = 0;
    act  = 0;
    errs = 0;
    rem1 = '0;
    tag  = $sformatf("v%0d", idx);
    exp_q.push_back(v.exp_reg);
    wait_ready(tag);
    issue(v.op, v.cnt, v.data, v.fill);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) rem1 = remaining;
      if (sr_fn != 2'b00) act++;
      if (err) errs++;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_done_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_active_cycles"}, 32'(act), 32'(v.exp_act));
    check({tag, "_err_pulses"}, 32'(errs), 32'(v.exp_err));
    check({tag, "_remaining_first"}, 32'(rem1), 32'(v.exp_rem1));
    check({tag, "_remaining_at_done"}, 32'(remaining), 32'd0);
    check({tag, "_register"}, 32'(reg_q), 32'(exp_q.pop_front()));
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'b000;
    cmd_if.cmd_cnt   = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_fill  = 1'b0;

    // Reset state
    #2;
    check("rst_sr_fn",     32'(sr_fn),     32'd0);
    check("rst_sli",       32'(sr_sli),    32'd0);
    check("rst_sri",       32'(sr_sri),    32'd0);
    check("rst_sr_in",     32'(sr_in),     32'd0);
    check("rst_clear",     32'(sr_clear),  32'd0);
    check("rst_ready",     32'(cmd_if.cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // op, cnt, data, fill, reg after, done latency, non-hold fn cycles, err pulses, remaining in T+1
    vecs.push_back('{3'b010, 3'd0, 4'b1011, 1'b0, 4'b1011, 2, 1, 0, 3'd0});
    vecs.push_back('{3'b011, 3'd2, 4'b0000, 1'b0, 4'b1100, 3, 2, 0, 3'd2});
    vecs.push_back('{3'b100, 3'd1, 4'b0000, 1'b1, 4'b1110, 2, 1, 0, 3'd1});
    vecs.push_back('{3'b011, 3'd0, 4'b0000, 1'b1, 4'b1110, 1, 0, 0, 3'd0});
    vecs.push_back('{3'b000, 3'd3, 4'b0101, 1'b1, 4'b1110, 1, 0, 0, 3'd0});
    vecs.push_back('{3'b100, 3'd7, 4'b0000, 1'b0, 4'b0000, 5, 4, 0, 3'd4});
    vecs.push_back('{3'b010, 3'd0, 4'b0110, 1'b0, 4'b0110, 2, 1, 0, 3'd0});
    vecs.push_back('{3'b011, 3'd1, 4'b0000, 1'b1, 4'b1101, 2, 1, 0, 3'd1});
    vecs.push_back('{3'b100, 3'd4, 4'b0000, 1'b1, 4'b1111, 5, 4, 0, 3'd4});
    vecs.push_back('{3'b001, 3'd0, 4'b0000, 1'b0, 4'b0000, 2, 0, 0, 3'd0});
    vecs.push_back('{3'b010, 3'd0, 4'b1001, 1'b0, 4'b1001, 2, 1, 0, 3'd0});
`ifdef USR_CTRL_ROTATE_EN
    vecs.push_back('{3'b110, 3'd1, 4'b0000, 1'b0, 4'b1100, 2, 1, 0, 3'd1});
    vecs.push_back('{3'b111, 3'd6, 4'b0000, 1'b0, 4'b1111, 5, 4, 0, 3'd4});
    vecs.push_back('{3'b010, 3'd0, 4'b1001, 1'b0, 4'b1001, 2, 1, 0, 3'd0});
    vecs.push_back('{3'b101, 3'd4, 4'b0000, 1'b0, 4'b1001, 5, 4, 0, 3'd4});
    vecs.push_back('{3'b101, 3'd1, 4'b0000, 1'b0, 4'b0011, 2, 1, 0, 3'd1});
    vecs.push_back('{3'b110, 3'd4, 4'b0000, 1'b1, 4'b0011, 5, 4, 0, 3'd4});
`else
    vecs.push_back('{3'b101, 3'd2, 4'b0000, 1'b0, 4'b1001, 2, 0, 1, 3'd0});
    vecs.push_back('{3'b111, 3'd3, 4'b0000, 1'b1, 4'b1001, 2, 0, 1, 3'd0});
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Abort on the second shift cycle of SHR 3, with a LOAD offered while busy
    run_vec('{3'b010, 3'd0, 4'b1111, 1'b0, 4'b1111, 2, 1, 0, 3'd0}, 90);
    wait_ready("abort_seq");
    issue(3'b100, 3'd3, 4'b0000, 1'b0);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'b010;
    cmd_if.cmd_data  = 4'b0000;
    @(negedge clk);
    check("abort_t1_fn",    32'(sr_fn),     32'd2);
    check("abort_t1_rem",   32'(remaining), 32'd3);
    check("abort_t1_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("abort_t2_reg",   32'(reg_q),     32'b0111);
    check("abort_t2_rem",   32'(remaining), 32'd2);
    abort = 1'b1;
    #1;
    check("abort_t2_fn",    32'(sr_fn),     32'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_t3_done",  32'(done),      32'd1);
    check("abort_t3_rem",   32'(remaining), 32'd0);
    check("abort_t3_ready", 32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_t4_done",  32'(done),      32'd0);
    check("abort_t4_busy",  32'(busy),      32'd0);
    @(negedge clk);
    check("abort_no_queue_reg",  32'(reg_q), 32'b0111);
    check("abort_no_queue_busy", 32'(busy),  32'd0);

    // Reset asserted mid-SHIFT
    run_vec('{3'b010, 3'd0, 4'b0101, 1'b0, 4'b0101, 2, 1, 0, 3'd0}, 91);
    wait_ready("reset_seq");
    issue(3'b011, 3'd4, 4'b0000, 1'b1);
    @(negedge clk);
    check("midrst_t1_fn", 32'(sr_fn), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_fn",    32'(sr_fn),     32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_rem",   32'(remaining), 32'd0);
    check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("midrst_reg",   32'(reg_q),     32'b1011);
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
    end
    check("midrst_after_busy", 32'(busy),  32'd0);
    check("midrst_after_reg",  32'(reg_q), 32'b1011);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
